// File: rtl/round_pkg.sv
// Shared types and widths for the round_off arbitration slice between the
// regime/mantissa-extraction stages and the packing stage.
package round_pkg;

    localparam int MANT_IN_W       = 64;
    localparam int K_W             = 6;
    localparam int MANT_OUT_W      = 32;
    localparam int DEFAULT_N_REQ   = 4;
    localparam int DEFAULT_TIMEOUT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/round_off_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit at or after ptr,
// wrapping modulo N_REQ (N_REQ need not be a power of two).
module rr_picker
    import round_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] ptr,
    output logic                     any_req,
    output logic [N_REQ-1:0]         winner_onehot,
    output logic [$clog2(N_REQ)-1:0] winner_idx
);

    localparam int IDX_W = $clog2(N_REQ);

    logic [IDX_W:0]   pos;
    logic [IDX_W-1:0] cand;

    always_comb begin
        any_req       = |req;
        winner_idx    = '0;
        winner_onehot = '0;
        pos           = '0;
        cand          = '0;
        // Scan from the farthest offset back to ptr so the nearest requester is the last to win.
        for (int off = N_REQ - 1; off >= 0; off--) begin
            pos = {1'b0, ptr} + (IDX_W + 1)'(off);
            if (pos >= (IDX_W + 1)'(N_REQ)) begin
                pos = pos - (IDX_W + 1)'(N_REQ);
            end
            cand = pos[IDX_W-1:0];
            if (req[cand]) begin
                winner_idx          = cand;
                winner_onehot       = '0;
                winner_onehot[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/round_off_arbiter.sv
// Shares one round_off rounding unit among N_REQ requesters with round-robin
// arbitration, a per-operation watchdog and a one-cycle ack per response.
module round_off_arbiter
    import round_pkg::*;
#(
    parameter int N_REQ   = DEFAULT_N_REQ,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_REQ-1:0]             req,
    input  logic [N_REQ*MANT_IN_W-1:0]   req_mant,
    input  logic [N_REQ*K_W-1:0]         req_k,
    output logic [N_REQ-1:0]             ack,
    output logic [MANT_OUT_W-1:0]        resp_mant,
    output logic                         resp_err,
    output logic [$clog2(N_REQ)-1:0]     grant_id,
    output logic                         busy,
    output logic                         ru_start,
    output logic [MANT_IN_W-1:0]         ru_shifted_mantissa,
    output logic [K_W-1:0]               ru_k_out,
    input  logic [MANT_OUT_W-1:0]        ru_mantissa_out,
    input  logic                         ru_done
);

    localparam int IDX_W   = $clog2(N_REQ);
    localparam int TIMER_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX   = IDX_W'(N_REQ - 1);

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] id);
        return (id == LAST_IDX) ? '0 : id + 1'b1;
    endfunction

    state_t               state;
    logic [IDX_W-1:0]     ptr;
    logic [TIMER_W-1:0]   timer;
    logic [N_REQ-1:0]     grant_onehot;

    logic                 any_req;
    logic [N_REQ-1:0]     win_onehot;
    logic [IDX_W-1:0]     win_idx;

    logic [MANT_IN_W-1:0] mant_slice [N_REQ];
    logic signed [K_W-1:0] k_slice   [N_REQ];

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign mant_slice[i] = req_mant[i*MANT_IN_W +: MANT_IN_W];
        assign k_slice[i]    = req_k[i*K_W +: K_W];
    end

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req           (req),
        .ptr           (ptr),
        .any_req       (any_req),
        .winner_onehot (win_onehot),
        .winner_idx    (win_idx)
    );

    // Every output is a register; each is updated on entry to the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= IDLE;
            ptr                 <= '0;
            timer               <= '0;
            grant_onehot        <= '0;
            grant_id            <= '0;
            ack                 <= '0;
            resp_mant           <= '0;
            resp_err            <= 1'b0;
            busy                <= 1'b0;
            ru_start            <= 1'b0;
            ru_shifted_mantissa <= '0;
            ru_k_out            <= '0;
        end else begin
            ru_start <= 1'b0;
            ack      <= '0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        ru_shifted_mantissa <= mant_slice[win_idx];
                        ru_k_out            <= k_slice[win_idx];
                        grant_id            <= win_idx;
                        grant_onehot        <= win_onehot;
                        ru_start            <= 1'b1;
                        busy                <= 1'b1;
                        state               <= ISSUE;
                    end
                end
                ISSUE: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A done on the final watchdog cycle still counts as success.
                    if (ru_done) begin
                        resp_mant <= ru_mantissa_out;
                        resp_err  <= 1'b0;
                        ack       <= grant_onehot;
                        state     <= RESP;
                    end else if (timer == TIMER_LAST) begin
                        resp_mant <= '0;
                        resp_err  <= 1'b1;
                        ack       <= grant_onehot;
                        state     <= RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                RESP: begin
                    ptr   <= next_ptr(grant_id);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_round_off_arbiter.sv
// Directed-plus-random bench for round_off_arbiter with a behavioural stub of
// the rounding unit and a round-robin reference model.
module tb_round_off_arbiter;

    localparam int N       = 4;
    localparam int TIMEOUT = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N*64-1:0] req_mant;
    logic [N*6-1:0]  req_k;
    logic [N-1:0] ack;
    logic [31:0]  resp_mant;
    logic         resp_err;
    logic [1:0]   grant_id;
    logic         busy;
    logic         ru_start;
    logic [63:0]  ru_shifted_mantissa;
    logic [5:0]   ru_k_out;
    logic [31:0]  ru_mantissa_out;
    logic         ru_done;

    logic [63:0]  mant_v [N];
    logic [5:0]   k_v    [N];

    int           stub_lat;
    bit           force_en;
    logic [31:0]  force_val;
    logic         inj_done;
    logic         stub_done;
    logic [31:0]  stub_res;
    int           stub_cnt;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           cyc   = 0;
    int           m_ptr;

    round_off_arbiter #(.N_REQ(N), .TIMEOUT(TIMEOUT)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .req                 (req),
        .req_mant            (req_mant),
        .req_k               (req_k),
        .ack                 (ack),
        .resp_mant           (resp_mant),
        .resp_err            (resp_err),
        .grant_id            (grant_id),
        .busy                (busy),
        .ru_start            (ru_start),
        .ru_shifted_mantissa (ru_shifted_mantissa),
        .ru_k_out            (ru_k_out),
        .ru_mantissa_out     (ru_mantissa_out),
        .ru_done             (ru_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always_comb begin
        req_mant = '0;
        req_k    = '0;
        for (int i = 0; i < N; i++) begin
            req_mant[64*i +: 64] = mant_v[i];
            req_k[6*i +: 6]      = k_v[i];
        end
    end

    // Rounding-unit stub: result is a simple arithmetic function of its operands.
    function automatic logic [31:0] stub_fn(input logic [63:0] m, input logic [5:0] k);
        return m[47:16] + {{26{k[5]}}, k};
    endfunction

    function automatic logic [31:0] stub_calc();
        return force_en ? force_val : stub_fn(ru_shifted_mantissa, ru_k_out);
    endfunction

    // done arrives stub_lat cycles after the start cycle; stub_lat = 0 means never.
    always @(posedge clk) begin
        if (rst) begin
            stub_done <= 1'b0;
            stub_cnt  <= 0;
        end else begin
            stub_done <= 1'b0;
            if (ru_start) begin
                stub_cnt <= 0;
                if (stub_lat == 1) begin
                    stub_done <= 1'b1;
                    stub_res  <= stub_calc();
                end else if (stub_lat > 1) begin
                    stub_cnt <= stub_lat - 1;
                end
            end else if (stub_cnt == 1) begin
                stub_done <= 1'b1;
                stub_res  <= stub_calc();
                stub_cnt  <= 0;
            end else if (stub_cnt > 1) begin
                stub_cnt <= stub_cnt - 1;
            end
        end
    end

    assign ru_done         = stub_done | inj_done;
    assign ru_mantissa_out = stub_res;

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int o = 0; o < N; o++) begin
            if (r[(p + o) % N]) return (p + o) % N;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero_state(input string tag);
        chk({tag, "_ack"}, ack, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_ru_start"}, ru_start, 0);
        chk({tag, "_grant_id"}, grant_id, 0);
        chk({tag, "_resp_mant"}, resp_mant, 0);
        chk({tag, "_resp_err"}, resp_err, 0);
        chk({tag, "_ru_mant"}, ru_shifted_mantissa, 0);
        chk({tag, "_ru_k"}, ru_k_out, 0);
    endtask

    // One grant: wait for the issue, check operands, hold, latency and response.
    task automatic serve(input int id, input bit drop, input bit scramble,
                         output int got_id, output int ack_cyc, output int start_n);
        logic [63:0] sm;
        logic [5:0]  sk;
        logic [31:0] emant;
        bit          eerr;
        int          ewait;
        int          n;
        sm    = mant_v[id];
        sk    = k_v[id];
        eerr  = (stub_lat == 0) || (stub_lat > TIMEOUT);
        emant = eerr ? 32'h0 : (force_en ? force_val : stub_fn(sm, sk));
        ewait = eerr ? TIMEOUT + 1 : stub_lat + 1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ru_start !== 1'b1 && n < 40);
        start_n = n;
        chk("start_seen", ru_start, 1);
        got_id = int'(grant_id);
        chk("grant_id", grant_id, id);
        chk("op_mant", ru_shifted_mantissa, sm);
        chk("op_k", ru_k_out, sk);
        if (scramble) begin
            mant_v[id] = {$urandom, $urandom};
            k_v[id]    = 6'($urandom);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) chk("start_pulse", ru_start, 0);
            chk("op_mant_hold", ru_shifted_mantissa, sm);
            chk("op_k_hold", ru_k_out, sk);
        end while (ack === '0 && n < 40);
        chk("ack_delay", n, ewait);
        chk("ack_onehot", ack, 64'd1 << id);
        chk("resp_mant", resp_mant, emant);
        chk("resp_err", resp_err, eerr);
        ack_cyc = cyc;
        if (drop) req[id] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, required finish");
        $fatal(1);
    end

    initial begin
        int g, c, sn, prev_c, prev_g, id, acks, n;
        logic [N-1:0] mask;

        rst = 1'b1; req = '0; stub_lat = 4; force_en = 0; force_val = '0; inj_done = 1'b0;
        for (int i = 0; i < N; i++) begin mant_v[i] = '0; k_v[i] = '0; end
        repeat (3) @(negedge clk);
        chk_zero_state("reset");
        rst = 1'b0;
        m_ptr = 0;

        // Single request with a fixed unit result.
        mant_v[0] = 64'h3FFF_0000_1234_5678; k_v[0] = 6'd2;
        force_en = 1; force_val = 32'hA5A5_0000;
        req = 4'b0001;
        serve(0, 1, 0, g, c, sn);
        chk("single_start_latency", sn, 1);
        force_en = 0;
        m_ptr = 1;
        @(negedge clk);
        chk("single_ack_clear", ack, 0);
        chk("single_idle", busy, 0);
        chk("single_mant_hold", resp_mant, 32'hA5A5_0000);
        chk("single_gid_hold", grant_id, 0);

        // All four requesters held from reset.
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin mant_v[i] = {$urandom, $urandom}; k_v[i] = 6'($urandom); end
        req = 4'b1111;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        m_ptr = 0; prev_c = 0;
        for (int i = 0; i < N; i++) begin
            id = pick(req, m_ptr);
            serve(id, 1, 0, g, c, sn);
            chk("all4_order", g, i);
            if (i > 0) chk("all4_period", c - prev_c, 7);
            prev_c = c;
            m_ptr = (id + 1) % N;
        end

        // Fairness: requesters 1 and 3 held continuously.
        for (int i = 0; i < N; i++) begin mant_v[i] = {$urandom, $urandom}; k_v[i] = 6'($urandom); end
        req = 4'b1010; prev_g = -1;
        for (int k = 0; k < 4; k++) begin
            id = pick(req, m_ptr);
            serve(id, 0, 0, g, c, sn);
            chk("fair_order", g, (k % 2 == 0) ? 1 : 3);
            if (k > 0) chk("fair_no_repeat", g != prev_g, 1);
            prev_g = g;
            m_ptr = (id + 1) % N;
        end
        req = '0;

        // Hung unit, then a stray done while idle.
        stub_lat = 0;
        mant_v[2] = {$urandom, $urandom}; k_v[2] = 6'($urandom);
        req = 4'b0100;
        id = pick(req, m_ptr);
        serve(id, 1, 0, g, c, sn);
        m_ptr = (id + 1) % N;
        @(negedge clk);
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack !== '0 || ru_start !== 1'b0) acks++;
        end
        chk("late_done_ignored", acks, 0);
        chk("late_done_idle", busy, 0);
        chk("err_hold", resp_err, 1);
        chk("err_mant_hold", resp_mant, 0);

        // Reset during WAIT with requesters 2 and 3 pending.
        req = 4'b0100;
        n = 0;
        do begin @(negedge clk); n++; end while (ru_start !== 1'b1 && n < 40);
        chk("rstw_start", ru_start, 1);
        chk("rstw_grant", grant_id, 2);
        req = 4'b1100;
        repeat (3) @(negedge clk);
        chk("rstw_busy", busy, 1);
        rst = 1'b1; stub_lat = 4;
        @(negedge clk);
        chk_zero_state("rstw");
        rst = 1'b0;
        m_ptr = 0;
        id = pick(req, m_ptr);
        serve(id, 1, 0, g, c, sn);
        chk("rstw_regrant", g, 2);
        chk("rstw_regrant_latency", sn, 1);
        m_ptr = (id + 1) % N;
        id = pick(req, m_ptr);
        serve(id, 1, 0, g, c, sn);
        m_ptr = (id + 1) % N;

        // Negative k with operands changed after accept.
        mant_v[0] = {$urandom, $urandom}; k_v[0] = 6'b111110;
        req = 4'b0001;
        id = pick(req, m_ptr);
        serve(id, 1, 1, g, c, sn);
        chk("neg_k_held", ru_k_out, 6'b111110);
        m_ptr = (id + 1) % N;

        // Watchdog boundary: done on the last WAIT cycle, then one cycle too late.
        stub_lat = TIMEOUT;
        mant_v[1] = {$urandom, $urandom}; k_v[1] = 6'($urandom);
        req = 4'b0010;
        id = pick(req, m_ptr);
        serve(id, 1, 0, g, c, sn);
        m_ptr = (id + 1) % N;
        stub_lat = TIMEOUT + 1;
        mant_v[2] = {$urandom, $urandom}; k_v[2] = 6'($urandom);
        req = 4'b0100;
        id = pick(req, m_ptr);
        serve(id, 1, 0, g, c, sn);
        m_ptr = (id + 1) % N;
        @(negedge clk);
        chk("late_after_timeout_ack", ack, 0);
        chk("late_after_timeout_idle", busy, 0);

        // Random request sets, operands and unit latencies.
        for (int r = 0; r < 6; r++) begin
            mask = 4'($urandom_range(1, 15));
            for (int i = 0; i < N; i++) begin mant_v[i] = {$urandom, $urandom}; k_v[i] = 6'($urandom); end
            req = mask;
            while (req != '0) begin
                stub_lat = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 20));
                id = pick(req, m_ptr);
                serve(id, 1, 1'($urandom_range(0, 1)), g, c, sn);
                m_ptr = (id + 1) % N;
            end
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
